// File: rtl/crc_frame_receiver.sv
// crc_frame_receiver: receive-side framer for the CRC-8 / FSK link.
// Hunts for SYNC_WORD in the demodulated bit stream. It then shifts in a
// 16-bit codeword {data, crc}, MSB first, checking CRC-8 (poly 0x07) serially.
// The data byte is delivered through a valid/ready output register.
//
// Ports:
//   sys_clk, reset     clock, asynchronous active-high reset
//   bit_in, bit_stb    demodulated bit, qualified by a one-cycle symbol strobe
//   out_data/out_valid received byte and its valid flag
//   out_ready          consumer accept (transfer on out_valid & out_ready)
//   crc_err            CRC failure flag for the byte on out_data
//   overrun            one-cycle pulse: finished frame dropped, output full
//   frame_cnt/err_cnt  wrapping counters of finished / CRC-failed frames
//   state_o            FSM state (HUNT=0, DATA=1, CHECK=2)
//
// Optional build macro CRC_ERR_DROP_EN: bad frames are counted but never
// delivered; crc_err stays 0 and bad frames never raise overrun.
module crc_frame_receiver #(
    parameter logic [7:0]  SYNC_WORD = 8'h7E,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_stb,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             crc_err,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state_o
);

    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_sync_sr;
    logic [15:0]        r_data_sr;
    logic [7:0]         r_crc;
    logic [3:0]         r_bit_cnt;
    logic [IDLE_W-1:0]  r_idle;
    logic [7:0]         r_out_data;
    logic               r_out_valid;
    logic               r_crc_err;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic [7:0]         w_sync_nxt;
    logic               w_sync_hit;
    logic               w_fb;
    logic [7:0]         w_crc_nxt;
    logic               w_idle_expired;
    logic               w_bad;
    logic               w_out_free;
    logic               w_accept;
    logic               w_deliver;
    logic               w_err_flag;
    logic               w_load;
    logic               w_overrun;

    assign w_sync_nxt     = {r_sync_sr[6:0], bit_in};
    assign w_sync_hit     = (w_sync_nxt == SYNC_WORD);
    assign w_fb           = r_crc[7] ^ bit_in;
    assign w_crc_nxt      = {r_crc[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
    assign w_idle_expired = (r_idle == IDLE_W'(TIMEOUT - 1));
    assign w_bad          = (r_crc != 8'h00);
    // Register is free when empty or being drained this very cycle.
    assign w_out_free     = ~r_out_valid | out_ready;
    assign w_accept       = r_out_valid & out_ready;

`ifdef CRC_ERR_DROP_EN
    assign w_deliver  = ~w_bad;
    assign w_err_flag = 1'b0;
`else
    assign w_deliver  = 1'b1;
    assign w_err_flag = w_bad;
`endif

    // State register.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) r_state <= ST_HUNT;
        else       r_state <= w_state_nxt;
    end

    // Next-state and CHECK-cycle output decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (bit_stb && w_sync_hit) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_stb) begin
                    if (r_bit_cnt == 4'd15) w_state_nxt = ST_CHECK;
                end else if (w_idle_expired) begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_HUNT;
                if (w_deliver) begin
                    if (w_out_free) w_load    = 1'b1;
                    else            w_overrun = 1'b1;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // Sync search, codeword shift, serial CRC and idle timer.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_sync_sr <= 8'h00;
            r_data_sr <= 16'h0000;
            r_crc     <= 8'h00;
            r_bit_cnt <= 4'd0;
            r_idle    <= '0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (bit_stb) begin
                        r_sync_sr <= w_sync_nxt;
                        if (w_sync_hit) begin
                            r_bit_cnt <= 4'd0;
                            r_crc     <= 8'h00;
                            r_idle    <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    // Kept clear outside HUNT so every hunt starts from zero.
                    r_sync_sr <= 8'h00;
                    if (bit_stb) begin
                        r_data_sr <= {r_data_sr[14:0], bit_in};
                        r_crc     <= w_crc_nxt;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_idle    <= '0;
                    end else if (!w_idle_expired) begin
                        r_idle <= r_idle + IDLE_W'(1);
                    end
                end
                default: r_sync_sr <= 8'h00;
            endcase
        end
    end

    // Output register, statistics and overrun pulse.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_overrun <= w_overrun;
            if (r_state == ST_CHECK) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                if (w_bad) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_out_data  <= r_data_sr[15:8];
                r_crc_err   <= w_err_flag;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign crc_err   = r_crc_err;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
    assign state_o   = r_state;

endmodule

// File: tb/tb_crc_frame_receiver.sv
// Testbench for crc_frame_receiver: frame-level reference model compared every
// cycle, plus directed literal checks for the documented scenarios.
module tb_crc_frame_receiver;

    localparam int unsigned TIMEOUT = 1024;
    localparam int unsigned CNT_W   = 16;

    logic             sys_clk = 1'b0;
    logic             reset   = 1'b0;
    logic             bit_in  = 1'b0;
    logic             bit_stb = 1'b0;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             crc_err;
    logic             overrun;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       state_o;

    int checks = 0;
    int errors = 0;

    crc_frame_receiver #(
        .SYNC_WORD (8'h7E),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_stb   (bit_stb),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .crc_err   (crc_err),
        .overrun   (overrun),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .state_o   (state_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // CRC-8 as the remainder of {data, 8'h00} divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [15:0] v;
        v = {d, 8'h00};
        for (int i = 15; i >= 8; i--)
            if (v[i]) v = v ^ (16'h0107 << (i - 8));
        return v[7:0];
    endfunction

`ifdef CRC_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    // Frame-level reference model: 0 hunting, 1 collecting, 2 frame complete.
    int          m_mode;
    logic [7:0]  m_win;
    logic [15:0] m_frame;
    int          m_nbits;
    int          m_idle;
    logic        e_valid, e_err, e_ovr;
    logic [7:0]  e_data;
    logic [15:0] e_fcnt, e_ecnt;
    logic        m_acc, m_bad;

    always @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_win = 8'h00; m_frame = 16'h0; m_nbits = 0; m_idle = 0;
            e_valid = 1'b0; e_err = 1'b0; e_ovr = 1'b0; e_data = 8'h00;
            e_fcnt = 16'h0; e_ecnt = 16'h0;
        end else begin
            e_ovr = 1'b0;
            m_acc = e_valid && out_ready;
            if (m_mode == 2) begin
                m_bad  = (crc8(m_frame[15:8]) != m_frame[7:0]);
                e_fcnt = e_fcnt + 16'd1;
                if (m_bad) e_ecnt = e_ecnt + 16'd1;
                if (!(DROP && m_bad)) begin
                    if (!e_valid || m_acc) begin
                        e_valid = 1'b1; e_data = m_frame[15:8]; e_err = m_bad;
                    end else begin
                        e_ovr = 1'b1;
                    end
                end else if (m_acc) begin
                    e_valid = 1'b0;
                end
                m_mode = 0; m_win = 8'h00;
            end else begin
                if (m_acc) e_valid = 1'b0;
                if (m_mode == 0) begin
                    if (bit_stb) begin
                        m_win = {m_win[6:0], bit_in};
                        if (m_win == 8'h7E) begin m_mode = 1; m_nbits = 0; m_idle = 0; end
                    end
                end else begin
                    if (bit_stb) begin
                        m_frame = {m_frame[14:0], bit_in};
                        m_nbits++;
                        m_idle = 0;
                        if (m_nbits == 16) m_mode = 2;
                    end else if (m_idle == int'(TIMEOUT) - 1) begin
                        m_mode = 0; m_win = 8'h00;
                    end else begin
                        m_idle++;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus event tallies.
    bit   cmp_en = 1'b0;
    int   ovr_seen = 0;
    int   vrise = 0;
    logic prev_valid = 1'b0;

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            if (e_valid) begin
                chk("out_data", 32'(out_data), 32'(e_data));
                chk("crc_err", 32'(crc_err), 32'(e_err));
            end
            chk("overrun", 32'(overrun), 32'(e_ovr));
            chk("frame_cnt", 32'(frame_cnt), 32'(e_fcnt));
            chk("err_cnt", 32'(err_cnt), 32'(e_ecnt));
            chk("state_o", 32'(state_o), 32'(m_mode));
            if (overrun) ovr_seen++;
            if (out_valid && !prev_valid) vrise++;
        end
        prev_valid = out_valid;
    end

    task automatic send_bit(input logic b, input int gap);
        bit_in  = b;
        bit_stb = 1'b1;
        @(negedge sys_clk);
        bit_stb = 1'b0;
        repeat (gap - 1) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    // Sends a 16-bit codeword; returns in the cycle after the last strobe.
    task automatic send_open(input logic [15:0] w, input int gap);
        for (int i = 15; i >= 1; i--) send_bit(w[i], gap);
        bit_in  = w[0];
        bit_stb = 1'b1;
        @(negedge sys_clk);
        bit_stb = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] w, input int gap);
        send_byte(8'h7E, gap);
        for (int i = 15; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        #2 reset = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        #2 reset = 1'b0;
        @(negedge sys_clk);
        ovr_seen = 0;
        vrise    = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_crcerr"}, 32'(crc_err), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_ecnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
    endtask

    initial begin
        // Pin the model's CRC against hand-computed codewords.
        chk("model_crc_bb", 32'(crc8(8'hBB)), 32'h28);
        chk("model_crc_f0", 32'(crc8(8'hF0)), 32'hDE);
        chk("model_crc_f8_bad", 32'(crc8(8'hF8) == 8'hDE), 32'd0);

        do_reset();
        cmp_en = 1'b1;
        chk_reset_state("rst");

        // Good frame 0xBB28 at one strobe per 8 clocks, latency of 2 cycles.
        send_byte(8'h7E, 8);
        send_open(16'hBB28, 8);
        chk("t1_check_state", 32'(state_o), 32'd2);
        chk("t1_valid_early", 32'(out_valid), 32'd0);
        @(negedge sys_clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hBB);
        chk("t1_crcerr", 32'(crc_err), 32'd0);
        chk("t1_fcnt", 32'(frame_cnt), 32'd1);
        chk("t1_ecnt", 32'(err_cnt), 32'd0);
        out_ready = 1'b1;
        @(negedge sys_clk);
        out_ready = 1'b0;
        chk("t1_drained", 32'(out_valid), 32'd0);

        // Corrupted frame 0xF8DE.
        do_reset();
        send_frame(16'hF8DE, 8);
        chk("t2_ecnt", 32'(err_cnt), 32'd1);
        chk("t2_fcnt", 32'(frame_cnt), 32'd1);
`ifdef CRC_ERR_DROP_EN
        chk("t2_valid", 32'(out_valid), 32'd0);
`else
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_data", 32'(out_data), 32'hF8);
        chk("t2_crcerr", 32'(crc_err), 32'd1);
`endif

        // Back-to-back frames with the consumer stalled.
        do_reset();
        send_frame(16'hBB28, 8);
        send_frame(16'hF0DE, 8);
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_data", 32'(out_data), 32'hBB);
        chk("t3_fcnt", 32'(frame_cnt), 32'd2);
        chk("t3_ovr_pulses", 32'(ovr_seen), 32'd1);
        out_ready = 1'b1;
        @(negedge sys_clk);
        out_ready = 1'b0;
        chk("t3_drained", 32'(out_valid), 32'd0);

        // Timeout after 9 data bits, then a good frame.
        do_reset();
        send_byte(8'h7E, 8);
        for (int i = 0; i < 9; i++) send_bit(i[0], 8);
        repeat (1100) @(negedge sys_clk);
        chk("t4_state", 32'(state_o), 32'd0);
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_fcnt", 32'(frame_cnt), 32'd0);
        chk("t4_ecnt", 32'(err_cnt), 32'd0);
        send_frame(16'hBB28, 8);
        chk("t4_data", 32'(out_data), 32'hBB);
        chk("t4_fcnt2", 32'(frame_cnt), 32'd1);

        // Noise without sync, then a real frame; then reset mid-DATA.
        do_reset();
        send_byte(8'h7F, 8);
        send_byte(8'h3E, 8);
        send_frame(16'hBB28, 8);
        chk("t5_frames", 32'(vrise), 32'd1);
        chk("t5_fcnt", 32'(frame_cnt), 32'd1);
        chk("t5_data", 32'(out_data), 32'hBB);
        send_byte(8'h7E, 8);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 8);
        chk("t5_in_data", 32'(state_o), 32'd1);
        #2 reset = 1'b1;
        @(negedge sys_clk);
        chk_reset_state("t5_rst");
        #2 reset = 1'b0;
        @(negedge sys_clk);
        chk("t5_post_state", 32'(state_o), 32'd0);

        // Handshake and CHECK reload in the same cycle.
        do_reset();
        send_frame(16'hBB28, 8);
        send_byte(8'h7E, 1);
        send_open(16'hF0DE, 1);
        out_ready = 1'b1;
        @(negedge sys_clk);
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_data", 32'(out_data), 32'hF0);
        chk("t6_crcerr", 32'(crc_err), 32'd0);
        chk("t6_no_ovr", 32'(ovr_seen), 32'd0);
        @(negedge sys_clk);
        out_ready = 1'b0;
        chk("t6_drained", 32'(out_valid), 32'd0);
        chk("t6_fcnt", 32'(frame_cnt), 32'd2);

        repeat (4) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
